// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline registers: control-bundle
// layout, default widths and the per-edge slot operation.
package pipe_pkg;

   localparam int CTRL_W_DEFAULT = 8;
   localparam int DATA_W_DEFAULT = 69;
   localparam int PC_W_DEFAULT   = 32;

   // Bit positions inside the default 8-bit control bundle.
   localparam int CTRL_REG_WRITE_BIT  = 0;
   localparam int CTRL_MEM_WRITE_BIT  = 1;
   localparam int CTRL_MEM_TO_REG_BIT = 2;
   localparam int CTRL_RES_LSB        = 3;
   localparam int CTRL_RES_W          = 2;

   typedef struct packed {
      logic [2:0] spare;
      logic [1:0] res;
      logic       mem_to_reg;
      logic       mem_write;
      logic       reg_write;
   } ctrl_fields_t;

   typedef enum logic [1:0] {
      HOLD   = 2'd0,
      LOAD   = 2'd1,
      SQUASH = 2'd2
   } slot_op_e;

   // flush outranks stall; reset is handled asynchronously in the slots.
   function automatic slot_op_e decide_op(input logic stall, input logic flush);
      slot_op_e op;
      op = LOAD;
      if (flush) begin
         op = SQUASH;
      end else if (stall) begin
         op = HOLD;
      end
      return op;
   endfunction

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Bundle between a pipeline stage, the hazard unit and a pipe_stage_reg.
// Counter outputs exist only when PIPE_STAGE_PERF_EN is defined.
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int PC_W   = PC_W_DEFAULT,
   parameter int DEPTH  = 1
);
   logic              stall;
   logic              flush;
   logic              valid_in;
   logic [CTRL_W-1:0] ctrl_in;
   logic [DATA_W-1:0] data_in;
   logic [PC_W-1:0]   pc_in;
   logic              valid_out;
   logic [CTRL_W-1:0] ctrl_out;
   logic [DATA_W-1:0] data_out;
   logic [PC_W-1:0]   pc_out;
   logic [DEPTH-1:0]  occupied;
`ifdef PIPE_STAGE_PERF_EN
   logic [31:0]       stall_cnt;
   logic [31:0]       flush_cnt;
   logic [31:0]       bubble_cnt;

   modport master (
      output stall, flush, valid_in, ctrl_in, data_in, pc_in,
      input  valid_out, ctrl_out, data_out, pc_out, occupied,
      input  stall_cnt, flush_cnt, bubble_cnt
   );
   modport slave (
      input  stall, flush, valid_in, ctrl_in, data_in, pc_in,
      output valid_out, ctrl_out, data_out, pc_out, occupied,
      output stall_cnt, flush_cnt, bubble_cnt
   );
`else
   modport master (
      output stall, flush, valid_in, ctrl_in, data_in, pc_in,
      input  valid_out, ctrl_out, data_out, pc_out, occupied
   );
   modport slave (
      input  stall, flush, valid_in, ctrl_in, data_in, pc_in,
      output valid_out, ctrl_out, data_out, pc_out, occupied
   );
`endif
endinterface

// File: rtl/pipe_stage_slot.sv
// One register slot of the stage chain: async clear, squash, hold or load,
// with the control field forced to zero whenever the slot is not valid.
module pipe_stage_slot
   import pipe_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int PC_W   = PC_W_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  slot_op_e          op,
   input  logic              valid_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [PC_W-1:0]   pc_i,
   output logic              valid_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [DATA_W-1:0] data_o,
   output logic [PC_W-1:0]   pc_o
);
   logic              valid_d, valid_q;
   logic [CTRL_W-1:0] ctrl_d, ctrl_q;
   logic [DATA_W-1:0] data_d, data_q;
   logic [PC_W-1:0]   pc_d, pc_q;

   always_comb begin
      valid_d = valid_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      pc_d    = pc_q;
      case (op)
         SQUASH: begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            data_d  = '0;
            pc_d    = '0;
         end
         LOAD: begin
            valid_d = valid_i;
            // A bubble must never carry live control bits downstream.
            ctrl_d  = valid_i ? ctrl_i : '0;
            data_d  = data_i;
            pc_d    = pc_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= '0;
         data_q  <= '0;
         pc_q    <= '0;
      end else begin
         valid_q <= valid_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         pc_q    <= pc_d;
      end
   end

   assign valid_o = valid_q;
   assign ctrl_o  = ctrl_q;
   assign data_o  = data_q;
   assign pc_o    = pc_q;
endmodule

// File: rtl/pipe_stage_reg.sv
// Parametrised inter-stage register: DEPTH chained slots with valid, stall and
// flush. Define PIPE_STAGE_PERF_EN to add saturating stall/flush/bubble counters.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int CTRL_W = CTRL_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT,
   parameter int PC_W   = PC_W_DEFAULT,
   parameter int DEPTH  = 1
) (
   input logic             clk,
   input logic             rst,
   pipe_stage_reg_if.slave bus
);
   if (DEPTH < 1 || DEPTH > 4) begin : g_depth_err
      $fatal(1, "pipe_stage_reg: DEPTH must be in 1..4");
   end

   slot_op_e                     op;
   logic [DEPTH-1:0]             valid_i, valid_s;
   logic [DEPTH-1:0][CTRL_W-1:0] ctrl_i, ctrl_s;
   logic [DEPTH-1:0][DATA_W-1:0] data_i, data_s;
   logic [DEPTH-1:0][PC_W-1:0]   pc_i, pc_s;

   // One decision per edge, shared by every slot so the chain moves in lockstep.
   assign op = decide_op(bus.stall, bus.flush);

   assign valid_i[0] = bus.valid_in;
   assign ctrl_i[0]  = bus.ctrl_in;
   assign data_i[0]  = bus.data_in;
   assign pc_i[0]    = bus.pc_in;

   for (genvar k = 1; k < DEPTH; k++) begin : g_link
      assign valid_i[k] = valid_s[k-1];
      assign ctrl_i[k]  = ctrl_s[k-1];
      assign data_i[k]  = data_s[k-1];
      assign pc_i[k]    = pc_s[k-1];
   end

   for (genvar k = 0; k < DEPTH; k++) begin : g_slot
      pipe_stage_slot #(
         .CTRL_W (CTRL_W),
         .DATA_W (DATA_W),
         .PC_W   (PC_W)
      ) u_slot (
         .clk     (clk),
         .rst     (rst),
         .op      (op),
         .valid_i (valid_i[k]),
         .ctrl_i  (ctrl_i[k]),
         .data_i  (data_i[k]),
         .pc_i    (pc_i[k]),
         .valid_o (valid_s[k]),
         .ctrl_o  (ctrl_s[k]),
         .data_o  (data_s[k]),
         .pc_o    (pc_s[k])
      );
   end

   assign bus.valid_out = valid_s[DEPTH-1];
   assign bus.ctrl_out  = ctrl_s[DEPTH-1];
   assign bus.data_out  = data_s[DEPTH-1];
   assign bus.pc_out    = pc_s[DEPTH-1];
   assign bus.occupied  = valid_s;

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt_d, stall_cnt_q;
   logic [31:0] flush_cnt_d, flush_cnt_q;
   logic [31:0] bubble_cnt_d, bubble_cnt_q;

   // Counters stick at all-ones rather than wrapping.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      flush_cnt_d  = flush_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (op == HOLD && stall_cnt_q != '1) begin
         stall_cnt_d = stall_cnt_q + 32'd1;
      end
      if (op == SQUASH && flush_cnt_q != '1) begin
         flush_cnt_d = flush_cnt_q + 32'd1;
      end
      if (op == LOAD && !bus.valid_in && bubble_cnt_q != '1) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_q  <= '0;
         flush_cnt_q  <= '0;
         bubble_cnt_q <= '0;
      end else begin
         stall_cnt_q  <= stall_cnt_d;
         flush_cnt_q  <= flush_cnt_d;
         bubble_cnt_q <= bubble_cnt_d;
      end
   end

   assign bus.stall_cnt  = stall_cnt_q;
   assign bus.flush_cnt  = flush_cnt_q;
   assign bus.bubble_cnt = bubble_cnt_q;
`endif
endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg at DEPTH 1, 2 and 3 driven by one shared stimulus;
// PIPE_STAGE_PERF_EN also enables the counter checks.
module tb_pipe_stage_reg;
   localparam int CW = 8;
   localparam int DW = 69;
   localparam int PW = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          stall = 1'b0, flush = 1'b0, valid_in = 1'b0;
   logic [CW-1:0] ctrl_in = '0;
   logic [DW-1:0] data_in = '0;
   logic [PW-1:0] pc_in = '0;

   int n_checks = 0;
   int n_pass   = 0;
   bit chk_en   = 1'b0;
   bit sat1     = 1'b0;

   always #5 clk = ~clk;

   pipe_stage_reg_if #(.DEPTH(1)) if1 ();
   pipe_stage_reg_if #(.DEPTH(2)) if2 ();
   pipe_stage_reg_if #(.DEPTH(3)) if3 ();

   assign if1.stall = stall;  assign if1.flush = flush;  assign if1.valid_in = valid_in;
   assign if1.ctrl_in = ctrl_in; assign if1.data_in = data_in; assign if1.pc_in = pc_in;
   assign if2.stall = stall;  assign if2.flush = flush;  assign if2.valid_in = valid_in;
   assign if2.ctrl_in = ctrl_in; assign if2.data_in = data_in; assign if2.pc_in = pc_in;
   assign if3.stall = stall;  assign if3.flush = flush;  assign if3.valid_in = valid_in;
   assign if3.ctrl_in = ctrl_in; assign if3.data_in = data_in; assign if3.pc_in = pc_in;

   pipe_stage_reg #(.DEPTH(1)) u_d1 (.clk(clk), .rst(rst), .bus(if1.slave));
   pipe_stage_reg #(.DEPTH(2)) u_d2 (.clk(clk), .rst(rst), .bus(if2.slave));
   pipe_stage_reg #(.DEPTH(3)) u_d3 (.clk(clk), .rst(rst), .bus(if3.slave));

   // Reference: the instruction stream as a list, youngest at index 0. A design
   // of depth D shows entry D-1; every depth sees the same list.
   typedef struct packed {
      logic          v;
      logic [CW-1:0] c;
      logic [DW-1:0] d;
      logic [PW-1:0] p;
   } slot_t;
   slot_t mdl [4];
   int    stall_n, flush_n, bubble_n;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < 4; k++) mdl[k] <= '0;
         stall_n <= 0; flush_n <= 0; bubble_n <= 0;
      end else if (flush) begin
         for (int k = 0; k < 4; k++) mdl[k] <= '0;
         flush_n <= flush_n + 1;
      end else if (stall) begin
         stall_n <= stall_n + 1;
      end else begin
         for (int k = 1; k < 4; k++) mdl[k] <= mdl[k-1];
         mdl[0] <= {valid_in, ({CW{valid_in}} & ctrl_in), data_in, pc_in};
         if (!valid_in) bubble_n <= bubble_n + 1;
      end
   end

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
   endtask

   task automatic cmp(input int depth, input logic v, input logic [CW-1:0] c,
                      input logic [DW-1:0] d, input logic [PW-1:0] p, input logic [3:0] occ);
      slot_t      e;
      logic [3:0] eo;
      e  = mdl[depth-1];
      eo = '0;
      for (int k = 0; k < depth; k++) eo[k] = mdl[k].v;
      check($sformatf("d%0d.valid_out", depth), 128'(v), 128'(e.v));
      check($sformatf("d%0d.ctrl_out", depth), 128'(c), 128'(e.c));
      check($sformatf("d%0d.data_out", depth), 128'(d), 128'(e.d));
      check($sformatf("d%0d.pc_out", depth), 128'(p), 128'(e.p));
      check($sformatf("d%0d.occupied", depth), 128'(occ), 128'(eo));
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         cmp(1, if1.valid_out, if1.ctrl_out, if1.data_out, if1.pc_out, 4'(if1.occupied));
         cmp(2, if2.valid_out, if2.ctrl_out, if2.data_out, if2.pc_out, 4'(if2.occupied));
         cmp(3, if3.valid_out, if3.ctrl_out, if3.data_out, if3.pc_out, 4'(if3.occupied));
`ifdef PIPE_STAGE_PERF_EN
         check("d1.stall_cnt", 128'(if1.stall_cnt), sat1 ? 128'(32'hFFFF_FFFF) : 128'(stall_n));
         check("d3.flush_cnt", 128'(if3.flush_cnt), 128'(flush_n));
         check("d2.bubble_cnt", 128'(if2.bubble_cnt), 128'(bubble_n));
`endif
      end
   end

   task automatic step(input logic v, input logic [CW-1:0] c, input logic [DW-1:0] d,
                       input logic [PW-1:0] p, input logic st, input logic fl);
      valid_in = v; ctrl_in = c; data_in = d; pc_in = p; stall = st; flush = fl;
      @(posedge clk);
      #1;
   endtask

   task automatic rand_cycle();
      stall    = ($urandom_range(0, 99) < 20);
      flush    = ($urandom_range(0, 99) < 6);
      valid_in = ($urandom_range(0, 99) < 75);
      ctrl_in  = CW'($urandom);
      data_in  = {5'($urandom), $urandom, $urandom};
      pc_in    = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 99) < 2) begin
         #3 rst = 1'b1;
         #2 rst = 1'b0;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #1 rst = 1'b1;
      #1;
      check("reset.d1.valid_out", 128'(if1.valid_out), 128'(0));
      check("reset.d2.occupied", 128'(if2.occupied), 128'(0));
      check("reset.d3.pc_out", 128'(if3.pc_out), 128'(0));
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;

      // Stall holds a single-slot register.
      step(1'b1, 8'h11, 69'h1, 32'h200, 1'b0, 1'b0);
      check("stall.pc_loaded", 128'(if1.pc_out), 128'(32'h200));
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h22, 69'h2, 32'h204, 1'b1, 1'b0);
         check("stall.pc_held", 128'(if1.pc_out), 128'(32'h200));
      end
      step(1'b1, 8'h22, 69'h2, 32'h204, 1'b0, 1'b0);
      check("stall.pc_after", 128'(if1.pc_out), 128'(32'h204));

      // Flush beats stall.
      step(1'b1, 8'hFF, 69'h123, 32'h300, 1'b0, 1'b0);
      check("flush.ctrl_pre", 128'(if1.ctrl_out), 128'(8'hFF));
      check("flush.data_pre", 128'(if1.data_out), 128'(69'h123));
      step(1'b1, 8'h33, 69'h5, 32'h304, 1'b1, 1'b1);
      check("flush.valid", 128'(if1.valid_out), 128'(0));
      check("flush.ctrl", 128'(if1.ctrl_out), 128'(0));
      check("flush.data", 128'(if1.data_out), 128'(0));
      check("flush.pc", 128'(if1.pc_out), 128'(0));

      // Bubble: control is gated, data still travels.
      step(1'b0, 8'hFF, 69'hDEAD, 32'h400, 1'b0, 1'b0);
      check("bubble.valid", 128'(if1.valid_out), 128'(0));
      check("bubble.ctrl", 128'(if1.ctrl_out), 128'(0));

      // Depth-3 chain fill, then the same fill with a stall on edge 2.
      step(1'b0, 8'h0, 69'h0, 32'h0, 1'b0, 1'b1);
      step(1'b1, 8'h01, 69'h10, 32'h0, 1'b0, 1'b0);
      check("chain.occ1", 128'(if3.occupied), 128'(3'b001));
      step(1'b1, 8'h02, 69'h11, 32'h4, 1'b0, 1'b0);
      check("chain.occ2", 128'(if3.occupied), 128'(3'b011));
      step(1'b1, 8'h03, 69'h12, 32'h8, 1'b0, 1'b0);
      check("chain.occ3", 128'(if3.occupied), 128'(3'b111));
      check("chain.pc3", 128'(if3.pc_out), 128'(32'h0));
      check("chain.ctrl3", 128'(if3.ctrl_out), 128'(8'h01));
      step(1'b0, 8'h0, 69'h0, 32'h0, 1'b0, 1'b1);
      step(1'b1, 8'h01, 69'h10, 32'h0, 1'b0, 1'b0);
      step(1'b1, 8'h02, 69'h11, 32'h4, 1'b1, 1'b0);
      check("chain_st.occ2", 128'(if3.occupied), 128'(3'b001));
      step(1'b1, 8'h02, 69'h11, 32'h4, 1'b0, 1'b0);
      check("chain_st.valid3", 128'(if3.valid_out), 128'(0));
      step(1'b1, 8'h03, 69'h12, 32'h8, 1'b0, 1'b0);
      check("chain_st.valid4", 128'(if3.valid_out), 128'(1));
      check("chain_st.pc4", 128'(if3.pc_out), 128'(32'h0));

      // Asynchronous reset with DEPTH=2 full.
      step(1'b1, 8'h44, 69'h20, 32'h500, 1'b0, 1'b0);
      step(1'b1, 8'h45, 69'h21, 32'h504, 1'b0, 1'b0);
      check("areset.occ_pre", 128'(if2.occupied), 128'(2'b11));
      #2 rst = 1'b1;
      #1;
      check("areset.occ", 128'(if2.occupied), 128'(0));
      check("areset.valid", 128'(if2.valid_out), 128'(0));
      check("areset.ctrl", 128'(if2.ctrl_out), 128'(0));
      check("areset.pc", 128'(if2.pc_out), 128'(0));
      @(posedge clk);
      #1 rst = 1'b0;
      step(1'b1, 8'hA5, 69'h77, 32'h100, 1'b0, 1'b0);
      check("areset.occ_load", 128'(if2.occupied), 128'(2'b01));
      step(1'b0, 8'h0, 69'h0, 32'h0, 1'b0, 1'b0);
      check("areset.valid2", 128'(if2.valid_out), 128'(1));
      check("areset.ctrl2", 128'(if2.ctrl_out), 128'(8'hA5));
      check("areset.pc2", 128'(if2.pc_out), 128'(32'h100));

`ifdef PIPE_STAGE_PERF_EN
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      for (int i = 0; i < 5; i++) step(1'b1, 8'h1, 69'h1, 32'h4, 1'b1, 1'b0);
      for (int i = 0; i < 2; i++) step(1'b1, 8'h1, 69'h1, 32'h4, 1'b0, 1'b1);
      for (int i = 0; i < 3; i++) step(1'b0, 8'h1, 69'h1, 32'h4, 1'b0, 1'b0);
      check("perf.stall_cnt", 128'(if1.stall_cnt), 128'(5));
      check("perf.flush_cnt", 128'(if1.flush_cnt), 128'(2));
      check("perf.bubble_cnt", 128'(if1.bubble_cnt), 128'(3));
`endif

      for (int i = 0; i < 600; i++) rand_cycle();

`ifdef PIPE_STAGE_PERF_EN
      force u_d1.stall_cnt_q = 32'hFFFF_FFFF;
      sat1 = 1'b1;
      #1 release u_d1.stall_cnt_q;
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 8'h1, 69'h1, 32'h4, 1'b1, 1'b0);
         check("perf.stall_sat", 128'(if1.stall_cnt), 128'(32'hFFFF_FFFF));
      end
`endif

      step(1'b0, 8'h0, 69'h0, 32'h0, 1'b0, 1'b0);
      chk_en = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
